// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Byte-stream program/data loader. Parses a 5-byte header
//                (TYPE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO), range-checks the
//                request, then emits one write strobe per 16-bit instruction
//                word (TYPE 00, two bytes each, high byte first) or per data
//                byte (TYPE 01, zero-extended) to the RAM select stage.
//  Ports       : clk1        - system clock, rising edge
//                rst_n       - asynchronous active-low reset
//                start       - begin a session (honoured in IDLE only)
//                byte_in     - stream byte
//                byte_valid  - byte_in valid
//                byte_ready  - loader accepts byte (transfer = valid & ready)
//                ARr_out     - RAM address
//                Inputs_out  - RAM write data
//                Write_out   - one-cycle write strobe
//                busy        - session in progress
//                done        - one-cycle pulse on successful completion
//                error       - sticky abort flag, cleared by next start
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter logic [15:0] IRAM_TOP  = 16'h03FF,
    parameter logic [15:0] DRAM_BASE = 16'h0400
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] ARr_out,
    output logic [15:0] Inputs_out,
    output logic        Write_out,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        H_TYPE = 4'd1,
        H_AHI  = 4'd2,
        H_ALO  = 4'd3,
        H_CHI  = 4'd4,
        H_CLO  = 4'd5,
        CHECK  = 4'd6,
        RX_HI  = 4'd7,
        RX_LO  = 4'd8,
        WRITE  = 4'd9,
        FIN    = 4'd10,
        ERR    = 4'd11
    } state_t;

    localparam logic [7:0] C_TYPE_INSTR = 8'h00;
    localparam logic [7:0] C_TYPE_DATA  = 8'h01;

    state_t      state_q, state_d;
    logic [7:0]  type_q,  type_d;
    logic [15:0] addr_q,  addr_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [7:0]  hi_q,    hi_d;
    logic [15:0] data_q,  data_d;
    logic        error_q, error_d;

    logic        w_accept;
    logic [16:0] w_last_addr;
    logic        w_is_instr;

    // Outputs are pure functions of state so reset forces them immediately.
    assign byte_ready = (state_q == H_TYPE) || (state_q == H_AHI) ||
                        (state_q == H_ALO)  || (state_q == H_CHI) ||
                        (state_q == H_CLO)  || (state_q == RX_HI) ||
                        (state_q == RX_LO);
    assign Write_out  = (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign error      = error_q;
    assign ARr_out    = addr_q;
    assign Inputs_out = data_q;

    assign w_accept    = byte_valid && byte_ready;
    assign w_is_instr  = (type_q == C_TYPE_INSTR);
    // 17 bits so an end address past 16'hFFFF is caught rather than wrapping.
    assign w_last_addr = {1'b0, addr_q} + {1'b0, cnt_q} - 17'd1;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        data_d  = data_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    state_d = H_TYPE;
                end
            end
            H_TYPE: if (w_accept) begin type_d = byte_in;         state_d = H_AHI; end
            H_AHI:  if (w_accept) begin addr_d[15:8] = byte_in;   state_d = H_ALO; end
            H_ALO:  if (w_accept) begin addr_d[7:0]  = byte_in;   state_d = H_CHI; end
            H_CHI:  if (w_accept) begin cnt_d[15:8]  = byte_in;   state_d = H_CLO; end
            H_CLO:  if (w_accept) begin cnt_d[7:0]   = byte_in;   state_d = CHECK; end
            CHECK: begin
                if ((type_q != C_TYPE_INSTR) && (type_q != C_TYPE_DATA)) begin
                    state_d = ERR;
                end else if (cnt_q == 16'd0) begin
                    state_d = FIN;
                end else if (w_is_instr) begin
                    state_d = (w_last_addr > {1'b0, IRAM_TOP}) ? ERR : RX_HI;
                end else begin
                    state_d = ((addr_q < DRAM_BASE) || (w_last_addr > 17'h0FFFF))
                              ? ERR : RX_LO;
                end
                if (state_d == ERR) begin
                    error_d = 1'b1;
                end
            end
            RX_HI: begin
                if (w_accept) begin
                    hi_d    = byte_in;
                    state_d = RX_LO;
                end
            end
            RX_LO: begin
                if (w_accept) begin
                    data_d  = w_is_instr ? {hi_q, byte_in} : {8'h00, byte_in};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d = addr_q + 16'd1;
                cnt_d  = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    state_d = FIN;
                end else begin
                    state_d = w_is_instr ? RX_HI : RX_LO;
                end
            end
            FIN:     state_d = IDLE;
            ERR: begin
                error_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            type_q  <= 8'h00;
            addr_q  <= 16'h0000;
            cnt_q   <= 16'h0000;
            hi_q    <= 8'h00;
            data_q  <= 16'h0000;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Scoreboard bench for prog_loader. Stimulus pushes expected
//                {address,data} writes into a queue; a monitor pops and
//                compares on every Write_out strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] ARr_out;
    logic [15:0] Inputs_out;
    logic        Write_out;
    logic        busy;
    logic        done;
    logic        error;

    int          checks   = 0;
    int          failures = 0;
    int          done_seen = 0;
    logic        prev_w = 1'b0;
    logic [31:0] sb[$];
    logic [7:0]  stim[$];

    always #5 clk1 = ~clk1;

    prog_loader #(.IRAM_TOP(16'h03FF), .DRAM_BASE(16'h0400)) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .ARr_out    (ARr_out),
        .Inputs_out (Inputs_out),
        .Write_out  (Write_out),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is compared against the scoreboard head.
    always @(negedge clk1) begin
        if (Write_out) begin
            check("write_pulse_width", {31'd0, prev_w}, 32'd0);
            check("ready_in_write", {31'd0, byte_ready}, 32'd0);
            if (sb.size() == 0) begin
                check("write_expected", 32'(sb.size()), 32'd1);
            end else begin
                check("write_addr_data", {ARr_out, Inputs_out}, sb.pop_front());
            end
        end
        if (done) done_seen++;
        prev_w = Write_out;
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 20) begin
            @(negedge clk1);
            n++;
        end
        if (!byte_ready) begin
            check("ready_timeout", {31'd0, byte_ready}, 32'd1);
        end else begin
            @(posedge clk1);
            @(negedge clk1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk1);
            n++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_clears_error", {31'd0, error}, 32'd0);
    endtask

    // Runs one session from the bytes in stim. hold_start keeps start high
    // through the header to show it is ignored while busy.
    task automatic run(input logic exp_err, input int exp_done, input logic hold_start);
        int base = done_seen;
        do_start();
        for (int i = 0; i < stim.size(); i++) begin
            if (hold_start && i == 1) start = 1'b1;
            send(stim[i]);
            if (i == 4) begin
                start = 1'b0;
                check("check_ready_low", {31'd0, byte_ready}, 32'd0);
            end
        end
        if (exp_err) begin
            @(negedge clk1);
            check("err_state_busy", {31'd0, busy}, 32'd1);
            @(negedge clk1);
            check("busy_low_after_err", {31'd0, busy}, 32'd0);
        end
        byte_valid = 1'b0;
        wait_idle();
        check("done_count", 32'(done_seen - base), 32'(exp_done));
        check("error_flag", {31'd0, error}, {31'd0, exp_err});
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        stim.delete();
        @(negedge clk1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        repeat (3) @(negedge clk1);
        check("rst_outputs", {ARr_out, Inputs_out}, 32'h0);
        check("rst_flags", {27'd0, byte_ready, Write_out, busy, done, error}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk1);

        // Two instruction words.
        stim = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
        sb.push_back({16'h0010, 16'hABCD});
        sb.push_back({16'h0011, 16'h1234});
        run(1'b0, 1, 1'b0);
        check("addr_hold_after_fin", {16'h0, ARr_out}, 32'h0012);

        // Three data bytes; start held high during the header.
        stim = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        sb.push_back({16'h0400, 16'h0011});
        sb.push_back({16'h0401, 16'h0022});
        sb.push_back({16'h0402, 16'h0033});
        run(1'b0, 1, 1'b1);
        check("addr_hold_after_data", {16'h0, ARr_out}, 32'h0403);

        // Instruction region overflow by one word.
        stim = '{8'h00, 8'h03, 8'hFF, 8'h00, 8'h02};
        run(1'b1, 0, 1'b0);
        check("addr_hold_after_err", {16'h0, ARr_out}, 32'h03FF);

        // Last instruction word exactly at IRAM_TOP.
        stim = '{8'h00, 8'h03, 8'hFF, 8'h00, 8'h01, 8'hAA, 8'hBB};
        sb.push_back({16'h03FF, 16'hAABB});
        run(1'b0, 1, 1'b0);

        // Data start one below DRAM_BASE.
        stim = '{8'h01, 8'h03, 8'hFF, 8'h00, 8'h01};
        run(1'b1, 0, 1'b0);

        // Unknown TYPE.
        stim = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h01};
        run(1'b1, 0, 1'b0);

        // Zero count: done with no write.
        stim = '{8'h00, 8'h12, 8'h34, 8'h00, 8'h00};
        run(1'b0, 1, 1'b0);

        // Data byte at 16'hFFFF is legal; two bytes from there overflow.
        stim = '{8'h01, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h5A};
        sb.push_back({16'hFFFF, 16'h005A});
        run(1'b0, 1, 1'b0);
        stim = '{8'h01, 8'hFF, 8'hFF, 8'h00, 8'h02};
        run(1'b1, 0, 1'b0);

        // Reset mid-session after the first payload byte.
        do_start();
        stim = '{8'h00, 8'h00, 8'h20, 8'h00, 8'h02, 8'hAB};
        foreach (stim[i]) send(stim[i]);
        stim.delete();
        byte_in = 8'hCD;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {ARr_out, Inputs_out}, 32'h0);
        check("midrst_flags", {27'd0, byte_ready, Write_out, busy, done, error}, 32'h0);
        @(negedge clk1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk1);
            check("no_session_without_start", {30'd0, busy, byte_ready}, 32'd0);
        end
        byte_valid = 1'b0;
        @(negedge clk1);

        // Fresh session after reset still works.
        stim = '{8'h01, 8'h05, 8'h00, 8'h00, 8'h01, 8'h77};
        sb.push_back({16'h0500, 16'h0077});
        run(1'b0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL have these ports, clock and reset first: clk1, input, 1, single system clock, all state on rising edge.
REQ-002 rst_n, input, 1, asynchronous active-low reset.
REQ-003 start, input, 1, begin a load session; sampled in IDLE only.
REQ-004 byte_in, input, 8, incoming stream byte.
REQ-005 byte_valid, input, 1, byte_in is valid this cycle.
REQ-006 byte_ready, output, 1, loader accepts byte this cycle; transfer occurs when byte_valid and byte_ready are both 1.
REQ-007 ARr_out, output, 16, memory address to the RAM select stage.
REQ-008 Inputs_out, output, 16, write data to the RAM select stage.
REQ-009 Write_out, output, 1, one-cycle write strobe to the RAM select stage.
REQ-010 busy, output, 1, a session is in progress.
REQ-011 done, output, 1, one-cycle pulse on successful session end.
REQ-012 error, output, 1, sticky session-abort flag.
REQ-013 Parameters: IRAM_TOP, default 16'h03FF, highest instruction address; DRAM_BASE, default 16'h0400, lowest data address.

Function
REQ-014 The stream format SHALL be: TYPE byte, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then payload.
REQ-015 TYPE 8'h00 SHALL select the instruction region, with 2 payload bytes per write (high byte first) forming a 16-bit word.
REQ-016 TYPE 8'h01 SHALL select the data region, with 1 payload byte per write and Inputs_out = {8'h00, byte}.
REQ-017 The FSM states SHALL be IDLE, H_TYPE, H_AHI, H_ALO, H_CHI, H_CLO, CHECK, RX_HI, RX_LO, WRITE, FIN, ERR.
REQ-018 From IDLE, start=1 SHALL go to H_TYPE and clear error in the same edge.
REQ-019 Each header state SHALL advance one state per accepted byte.
REQ-020 CHECK SHALL last exactly one cycle, with byte_ready=0.
REQ-021 CHECK SHALL go to ERR when TYPE is not 00/01.
REQ-022 CHECK SHALL go to ERR for TYPE=00 when start+cnt-1 > IRAM_TOP, computed in 17 bits.
REQ-023 CHECK SHALL go to ERR for TYPE=01 when start < DRAM_BASE or start+cnt-1 > 16'hFFFF, computed in 17 bits.
REQ-024 CHECK SHALL go to FIN when cnt==0, and the range check SHALL be skipped in that case.
REQ-025 Otherwise CHECK SHALL go to RX_HI for TYPE=00 or RX_LO for TYPE=01.
REQ-026 RX_HI SHALL latch the high byte; RX_LO SHALL latch the low or data byte and then go to WRITE.
REQ-027 WRITE SHALL assert Write_out=1 for exactly one cycle, with byte_ready=0 and ARr_out and Inputs_out stable across that cycle.
REQ-028 After WRITE, ARr_out SHALL increment by 1 and the remaining count SHALL decrement by 1.
REQ-029 After WRITE, the FSM SHALL go to FIN if the remaining count reaches 0, else back to RX_HI or RX_LO.
REQ-030 FIN SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-031 ERR SHALL set error=1 and go to IDLE next cycle; error SHALL hold until the next start.
REQ-032 byte_ready SHALL be 1 only in H_* and RX_* states.
REQ-033 Bytes offered while byte_ready=0 SHALL NOT be consumed.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-036 Write_out SHALL never assert outside WRITE.
REQ-037 Every write SHALL land in [0, IRAM_TOP] for TYPE 00 or [DRAM_BASE, FFFF] for TYPE 01.
REQ-038 ARr_out SHALL hold its last value in IDLE, FIN and ERR.

Reset
REQ-039 rst_n=0 SHALL immediately force state=IDLE, ARr_out=0, Inputs_out=0, Write_out=0, byte_ready=0, busy=0, done=0, error=0, and clear the count and latches.
REQ-040 Reset asserted mid-session SHALL abort the session with no further Write_out, and the next session SHALL require a new start.

Verification
REQ-041 Scenario: start; stream 00,00,10,00,02,AB,CD,12,34 -> Write_out at 0x0010 data 0xABCD, then at 0x0011 data 0x1234; done pulse; error=0.
REQ-042 Scenario: start; stream 01,04,00,00,03,11,22,33 -> writes 0x0011@0x0400, 0x0022@0x0401, 0x0033@0x0402; done pulse.
REQ-043 Scenario: start; stream 00,03,FF,00,02 -> error=1, no Write_out, busy=0 two cycles after CHECK.
REQ-044 Scenario: TYPE 01 with start address 0x03FF -> error=1; TYPE 07 -> error=1; cnt=0 -> done pulse with no write.
REQ-045 Scenario: byte_valid held high continuously through a session -> byte_ready drops in CHECK and WRITE, and every byte is consumed exactly once.
REQ-046 Scenario: rst_n pulsed low after the first payload byte -> all outputs return to reset values, no write; a start issued during busy is ignored.
